// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: operand widths,
// divide controller states and the R-type funct codes that select DIV/DIVU.
package muldiv_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  // Same funct encodings the decoder uses for its R-type path.
  localparam logic [5:0] FUNCT_DIV  = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_seq_ctrl_if.sv
// E-stage handshake between the pipeline and the divide controller.
// The pipeline side drives the master modport, the controller takes the slave modport.
interface div_seq_ctrl_if;
  import muldiv_pkg::*;

  logic             div_startE;
  logic             div_signedE;
  logic [WIDTH-1:0] src_aE;
  logic [WIDTH-1:0] src_bE;
  logic             flushE;
  logic             stallM;
  logic             div_stallE;
  logic             div_validE;
  logic [WIDTH-1:0] hi_oE;
  logic [WIDTH-1:0] lo_oE;
  logic             hilo_wenE;

  modport master (
    output div_startE, div_signedE, src_aE, src_bE, flushE, stallM,
    input  div_stallE, div_validE, hi_oE, lo_oE, hilo_wenE
  );

  modport slave (
    input  div_startE, div_signedE, src_aE, src_bE, flushE, stallM,
    output div_stallE, div_validE, hi_oE, lo_oE, hilo_wenE
  );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring divide iteration: shift {rem,quo} left, trial-subtract
// the divisor from the upper half and keep it only when it does not go negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem < divisor always holds, so the shifted value fits in WIDTH+1 bits and
  // the top bit of the difference is a clean borrow flag.
  assign shifted = {rem_i, quo_i[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_i};

  always_comb begin
    if (!diff[WIDTH]) begin
      rem_o = diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle DIV/DIVU controller for the E stage with HILO write strobe.
// Optional DIV_EARLY_EXIT_EN: finish in one cycle when |a| < |b| (nonzero b).
module div_seq_ctrl #(
  parameter int WIDTH = muldiv_pkg::WIDTH,
  parameter int CNT_W = muldiv_pkg::CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  div_seq_ctrl_if.slave bus
);
  import muldiv_pkg::*;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;

  logic             start_ok;
  logic             early_exit;
  logic             last_iter;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic             stall_o, valid_o;

  assign start_ok  = bus.div_startE & ~bus.flushE;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // DIVU operands are taken as-is; DIV works on magnitudes and fixes signs later.
  assign abs_a = (bus.div_signedE && bus.src_aE[WIDTH-1]) ? -bus.src_aE : bus.src_aE;
  assign abs_b = (bus.div_signedE && bus.src_bE[WIDTH-1]) ? -bus.src_bE : bus.src_bE;

`ifdef DIV_EARLY_EXIT_EN
  assign early_exit = (abs_b != '0) && (abs_a < abs_b);
`else
  assign early_exit = 1'b0;
`endif

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush beats everything, including a start arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    if (bus.flushE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.div_startE) state_d = early_exit ? DONE : CALC;
        CALC:    if (last_iter) state_d = FIX;
        FIX:     state_d = DONE;
        DONE:    if (!bus.stallM) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    stall_o = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      IDLE:      stall_o = start_ok;
      CALC, FIX: stall_o = 1'b1;
      DONE:      valid_o = 1'b1;
      default:   stall_o = 1'b0;
    endcase
  end

  assign bus.div_stallE = stall_o;
  assign bus.div_validE = valid_o;
  assign bus.hilo_wenE  = valid_o & ~bus.stallM & ~bus.flushE;
  assign bus.hi_oE      = hi_q;
  assign bus.lo_oE      = lo_q;

  // Datapath: hi/lo only change on a completed FIX or an early exit, so they
  // stay put for the whole DONE hold.
  always_comb begin
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          cnt_d  = '0;
          rem_d  = '0;
          quo_d  = abs_a;
          dvs_d  = abs_b;
          qneg_d = bus.div_signedE & (bus.src_aE[WIDTH-1] ^ bus.src_bE[WIDTH-1]);
          rneg_d = bus.div_signedE & bus.src_aE[WIDTH-1];
          if (early_exit) begin
            hi_d = bus.src_aE;
            lo_d = '0;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
      end
      FIX: begin
        if (!bus.flushE) begin
          lo_d = qneg_q ? -quo_q : quo_q;
          hi_d = rneg_q ? -rem_q : rem_q;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: vector table plus flush/hold/reset sequences.
// Honours DIV_EARLY_EXIT_EN when computing the expected stall length.
module tb_div_seq_ctrl;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expLo;
    logic [31:0] expHi;
  } vec_t;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
  } result_t;

`ifdef DIV_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  result_t sbQ[$];
  vec_t    vecs[10];

  div_seq_ctrl_if bus ();

  div_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic sgn, input logic [31:0] a,
                               input logic [31:0] b, input logic flush, input logic hold);
    bus.div_startE  = start;
    bus.div_signedE = sgn;
    bus.src_aE      = a;
    bus.src_bE      = b;
    bus.flushE      = flush;
    bus.stallM      = hold;
  endtask

  // Expected number of stall cycles, from the bench's own view of magnitudes.
  function automatic int expStall(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    ma = (sgn && a[31]) ? (32'd0 - a) : a;
    mb = (sgn && b[31]) ? (32'd0 - b) : b;
    if (EarlyExit && (mb != 32'd0) && (ma < mb)) return 1;
    return 34;
  endfunction

  // Issue one divide, count stall cycles, optionally hold DONE with stallM,
  // then check the single HILO write against the scoreboard.
  task automatic runDivide(input vec_t v, input int holdCycles);
    int      stallCnt;
    int      cycles;
    logic    hold;
    result_t exp;
    hold = (holdCycles > 0);
    @(posedge clk); #1;
    applyStimulus(1'b1, v.sgn, v.a, v.b, 1'b0, hold);
    sbQ.push_back('{lo: v.expLo, hi: v.expHi});
    stallCnt = 0;
    cycles   = 0;
    @(negedge clk);
    if (bus.div_stallE) stallCnt++;
    @(posedge clk); #1;
    applyStimulus(1'b0, v.sgn, v.a, v.b, 1'b0, hold);
    @(negedge clk);
    while (!bus.div_validE && cycles < 200) begin
      if (bus.div_stallE) stallCnt++;
      @(negedge clk);
      cycles++;
    end
    if (!bus.div_validE) begin
      checkOutput("done_timeout", {31'd0, bus.div_validE}, 32'd1);
      void'(sbQ.pop_front());
      bus.stallM = 1'b0;
      return;
    end
    checkOutput("stall_cycles", 32'(stallCnt), 32'(expStall(v.sgn, v.a, v.b)));
    checkOutput("stall_in_done", {31'd0, bus.div_stallE}, 32'd0);
    for (int i = 0; i < holdCycles; i++) begin
      checkOutput("hold_valid", {31'd0, bus.div_validE}, 32'd1);
      checkOutput("hold_wen", {31'd0, bus.hilo_wenE}, 32'd0);
      checkOutput("hold_lo", bus.lo_oE, v.expLo);
      checkOutput("hold_hi", bus.hi_oE, v.expHi);
      @(posedge clk); #1;
      if (i == holdCycles - 1) bus.stallM = 1'b0;
      @(negedge clk);
    end
    checkOutput("wen_pulse", {31'd0, bus.hilo_wenE}, 32'd1);
    checkOutput("valid_done", {31'd0, bus.div_validE}, 32'd1);
    if (sbQ.size() == 0) begin
      checkOutput("sb_empty", 32'd0, 32'd1);
    end else begin
      exp = sbQ.pop_front();
      checkOutput("sb_lo", bus.lo_oE, exp.lo);
      checkOutput("sb_hi", bus.hi_oE, exp.hi);
    end
    @(negedge clk);
    checkOutput("wen_single", {31'd0, bus.hilo_wenE}, 32'd0);
    checkOutput("valid_cleared", {31'd0, bus.div_validE}, 32'd0);
  endtask

  initial begin
    int   wenCnt;
    vec_t v;
    checks   = 0;
    failures = 0;

    vecs[0] = '{sgn: 1'b0, a: 32'd100,        b: 32'd7,          expLo: 32'd14,         expHi: 32'd2};
    vecs[1] = '{sgn: 1'b1, a: 32'hFFFF_FFF9,  b: 32'd2,          expLo: 32'hFFFF_FFFD,  expHi: 32'hFFFF_FFFF};
    vecs[2] = '{sgn: 1'b1, a: 32'd7,          b: 32'hFFFF_FFFE,  expLo: 32'hFFFF_FFFD,  expHi: 32'd1};
    vecs[3] = '{sgn: 1'b1, a: 32'h8000_0000,  b: 32'hFFFF_FFFF,  expLo: 32'h8000_0000,  expHi: 32'd0};
    vecs[4] = '{sgn: 1'b0, a: 32'd5,          b: 32'd0,          expLo: 32'hFFFF_FFFF,  expHi: 32'd5};
    vecs[5] = '{sgn: 1'b0, a: 32'd3,          b: 32'd10,         expLo: 32'd0,          expHi: 32'd3};
    vecs[6] = '{sgn: 1'b1, a: 32'hFFFF_FFFD,  b: 32'd10,         expLo: 32'd0,          expHi: 32'hFFFF_FFFD};
    vecs[7] = '{sgn: 1'b0, a: 32'hFFFF_FFFF,  b: 32'd3,          expLo: 32'h5555_5555,  expHi: 32'd0};
    vecs[8] = '{sgn: 1'b1, a: 32'hFFFF_FF9C,  b: 32'hFFFF_FFF9,  expLo: 32'd14,         expHi: 32'hFFFF_FFFE};
    vecs[9] = '{sgn: 1'b0, a: 32'h1234_5678,  b: 32'h0000_1000,  expLo: 32'h0001_2345,  expHi: 32'h0000_0678};

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_stall", {31'd0, bus.div_stallE}, 32'd0);
    checkOutput("reset_valid", {31'd0, bus.div_validE}, 32'd0);
    checkOutput("reset_wen", {31'd0, bus.hilo_wenE}, 32'd0);
    checkOutput("reset_lo", bus.lo_oE, 32'd0);
    checkOutput("reset_hi", bus.hi_oE, 32'd0);

    $display("[TB] vector table");
    for (int i = 0; i < 10; i++) runDivide(vecs[i], 0);

    $display("[TB] stallM hold on result");
    runDivide(vecs[0], 3);

    $display("[TB] flush mid-operation");
    wenCnt = 0;
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 32'd1000, 32'd3, 1'b0, 1'b0);
    @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      bus.div_startE = 1'b0;
      if (k == 10) bus.flushE = 1'b1;
      @(negedge clk);
      if (bus.hilo_wenE) wenCnt++;
    end
    checkOutput("flush_cycle_stall", {31'd0, bus.div_stallE}, 32'd1);
    @(posedge clk); #1;
    bus.flushE = 1'b0;
    @(negedge clk);
    if (bus.hilo_wenE) wenCnt++;
    checkOutput("flush_stall_low", {31'd0, bus.div_stallE}, 32'd0);
    checkOutput("flush_valid_low", {31'd0, bus.div_validE}, 32'd0);
    checkOutput("flush_no_wen", 32'(wenCnt), 32'd0);
    v = '{sgn: 1'b0, a: 32'd1000, b: 32'd3, expLo: 32'd333, expHi: 32'd1};
    runDivide(v, 0);

    $display("[TB] flush and start together");
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 32'd50, 32'd5, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("flush_start_stall", {31'd0, bus.div_stallE}, 32'd0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 32'd50, 32'd5, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("flush_start_idle", {31'd0, bus.div_stallE | bus.div_validE}, 32'd0);

    $display("[TB] reset mid-operation");
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 32'd77, 32'd4, 1'b0, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
      bus.div_startE = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_stall", {31'd0, bus.div_stallE}, 32'd0);
    checkOutput("midreset_lo", bus.lo_oE, 32'd0);
    checkOutput("midreset_hi", bus.hi_oE, 32'd0);
    wenCnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.hilo_wenE || bus.div_validE) wenCnt++;
    end
    checkOutput("midreset_no_write", 32'(wenCnt), 32'd0);

    checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
